// File: rtl/abcd_seq_pkg.sv
// Shared types and constants for the a/b/c/d four-phase handshake initiator.
package abcd_seq_pkg;
  typedef enum logic [2:0] {
    IDLE, DRV_A, WAIT_B, DRV_B, WAIT_C, DRV_C, WAIT_D, DRV_D
  } seq_state_t;

  localparam int DEF_GAP_AB  = 1;
  localparam int DEF_GAP_BC  = 2;
  localparam int DEF_GAP_CD  = 2;
  localparam int DEF_CNT_W   = 4;
  localparam int FRAME_CNT_W = 8;
endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter shared by every WAIT state; saturates at zero.
module gap_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)             cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/abcd_seq_driver.sv
// Drives one-cycle a/b/c/d pulses with programmable gaps and counts completed frames.
module abcd_seq_driver
  import abcd_seq_pkg::*;
#(
  parameter int GAP_AB = DEF_GAP_AB,
  parameter int GAP_BC = DEF_GAP_BC,
  parameter int GAP_CD = DEF_GAP_CD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   ready,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  if (GAP_AB < 1 || GAP_AB > (1 << CNT_W) ||
      GAP_BC < 1 || GAP_BC > (1 << CNT_W) ||
      GAP_CD < 1 || GAP_CD > (1 << CNT_W)) begin : g_bad_gap
    $error("abcd_seq_driver: GAP parameters must lie in 1..2**CNT_W");
  end

  // The WAIT state itself accounts for one cycle, so the counter gets GAP-2.
  localparam logic [CNT_W-1:0] LD_AB = CNT_W'((GAP_AB > 1) ? GAP_AB - 2 : 0);
  localparam logic [CNT_W-1:0] LD_BC = CNT_W'((GAP_BC > 1) ? GAP_BC - 2 : 0);
  localparam logic [CNT_W-1:0] LD_CD = CNT_W'((GAP_CD > 1) ? GAP_CD - 2 : 0);

  seq_state_t       state, state_nxt;
  logic             load, zero;
  logic [CNT_W-1:0] load_val;

  gap_counter #(.CNT_W(CNT_W)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    unique case (state)
      IDLE:   if (start) state_nxt = DRV_A;
      DRV_A:  if (GAP_AB > 1) begin state_nxt = WAIT_B; load = 1'b1; load_val = LD_AB; end
              else state_nxt = DRV_B;
      WAIT_B: if (zero) state_nxt = DRV_B;
      DRV_B:  if (GAP_BC > 1) begin state_nxt = WAIT_C; load = 1'b1; load_val = LD_BC; end
              else state_nxt = DRV_C;
      WAIT_C: if (zero) state_nxt = DRV_C;
      DRV_C:  if (GAP_CD > 1) begin state_nxt = WAIT_D; load = 1'b1; load_val = LD_CD; end
              else state_nxt = DRV_D;
      WAIT_D: if (zero) state_nxt = DRV_D;
      DRV_D:  state_nxt = start ? DRV_A : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over start, including the DRV_D restart path.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      d         <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      a     <= (state_nxt == DRV_A);
      b     <= (state_nxt == DRV_B);
      c     <= (state_nxt == DRV_C);
      d     <= (state_nxt == DRV_D);
      // DRV_D always lasts one cycle and the frame is complete even if aborted there.
      if (state == DRV_D) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign ready = (state == IDLE) || (state == DRV_D);
  assign done  = d;
endmodule

// File: tb/tb_abcd_seq_driver.sv
// Directed bench: default-gap driver plus a GAP 3/1/4 instance, per-scenario tasks.
module tb_abcd_seq_driver;
  logic clk = 1'b0;
  logic rst_n, start, abort, start1;
  logic ready, a, b, c, d, done;
  logic ready1, a1, b1, c1, d1, done1;
  logic [7:0] frame_cnt, frame_cnt1;
  int tests = 0;
  int fails = 0;
  logic [63:0] ah, bh, ch, dh, doneh, rdyh;

  always #5 clk = ~clk;

  abcd_seq_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
    .a(a), .b(b), .c(c), .d(d), .done(done), .frame_cnt(frame_cnt)
  );

  abcd_seq_driver #(.GAP_AB(3), .GAP_BC(1), .GAP_CD(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .ready(ready1),
    .a(a1), .b(b1), .c(c1), .d(d1), .done(done1), .frame_cnt(frame_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of each history word = value at offset i+1 after the start edge.
  task automatic sample_window(input int n);
    ah = '0; bh = '0; ch = '0; dh = '0; doneh = '0; rdyh = '0;
    for (int i = 0; i < n; i++) begin
      ah[i] = a; bh[i] = b; ch[i] = c; dh[i] = d; doneh[i] = done; rdyh[i] = ready;
      if (i == n - 1) start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; start1 = 1'b1;
    tick(); tick();
    tests++; if ({a, b, c, d, done} !== 5'b0) begin fails++; $display("FAIL reset_pulses got=%b exp=00000", {a, b, c, d, done}); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    tick();
    tests++; if (a !== 1'b0 || a1 !== 1'b0) begin fails++; $display("FAIL reset_start_ignored got a=%b a1=%b exp=0", a, a1); end
  endtask

  task automatic test_single();
    logic [7:0] f0;
    f0 = frame_cnt;
    start = 1'b1; tick(); start = 1'b0;
    sample_window(8);
    tests++; if (ah[7:0] !== 8'h01) begin fails++; $display("FAIL single_a got=%h exp=01", ah[7:0]); end
    tests++; if (bh[7:0] !== 8'h02) begin fails++; $display("FAIL single_b got=%h exp=02", bh[7:0]); end
    tests++; if (ch[7:0] !== 8'h08) begin fails++; $display("FAIL single_c got=%h exp=08", ch[7:0]); end
    tests++; if (dh[7:0] !== 8'h20) begin fails++; $display("FAIL single_d got=%h exp=20", dh[7:0]); end
    tests++; if (doneh[7:0] !== 8'h20) begin fails++; $display("FAIL single_done got=%h exp=20", doneh[7:0]); end
    tests++; if (rdyh[7:0] !== 8'hE0) begin fails++; $display("FAIL single_ready got=%h exp=e0", rdyh[7:0]); end
    tests++; if (frame_cnt !== f0 + 8'd1) begin fails++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt, f0 + 8'd1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f0;
    f0 = frame_cnt;
    start = 1'b1; tick();
    sample_window(18);
    tests++; if (ah[17:0] !== 18'h01041) begin fails++; $display("FAIL b2b_a got=%h exp=01041", ah[17:0]); end
    tests++; if (bh[17:0] !== 18'h02082) begin fails++; $display("FAIL b2b_b got=%h exp=02082", bh[17:0]); end
    tests++; if (ch[17:0] !== 18'h08208) begin fails++; $display("FAIL b2b_c got=%h exp=08208", ch[17:0]); end
    tests++; if (dh[17:0] !== 18'h20820) begin fails++; $display("FAIL b2b_d got=%h exp=20820", dh[17:0]); end
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL b2b_stop got a=%b exp=0", a); end
    tests++; if (frame_cnt !== f0 + 8'd3) begin fails++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", frame_cnt, f0 + 8'd3); end
  endtask

  task automatic test_abort();
    logic [7:0] f0;
    f0 = frame_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();                 // offset 3: WAIT_C
    abort = 1'b1; tick(); abort = 1'b0;
    tests++; if ({a, b, c, d, done} !== 5'b0) begin fails++; $display("FAIL abort_pulses got=%b exp=00000", {a, b, c, d, done}); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b exp=1", ready); end
    sample_window(6);
    tests++; if ((ch | dh | doneh) !== 64'd0) begin fails++; $display("FAIL abort_no_cd got c=%h d=%h exp=0", ch, dh); end
    tests++; if (frame_cnt !== f0) begin fails++; $display("FAIL abort_frame_cnt got=%0d exp=%0d", frame_cnt, f0); end
    // Abort in DRV_D: done stands, start is overridden, frame still counted.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL abort_d_done got=%b exp=1", done); end
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    tests++; if (a !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL abort_d_restart got a=%b ready=%b exp a=0 ready=1", a, ready); end
    tests++; if (frame_cnt !== f0 + 8'd1) begin fails++; $display("FAIL abort_d_frame_cnt got=%0d exp=%0d", frame_cnt, f0 + 8'd1); end
    abort = 1'b1; tick(); abort = 1'b0;
    tests++; if (ready !== 1'b1 || a !== 1'b0) begin fails++; $display("FAIL abort_idle got ready=%b a=%b exp 1/0", ready, a); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0; tick();
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL rstmid_b got=%b exp=1", b); end
    rst_n = 1'b0; start = 1'b1; tick();
    tests++; if ({a, b, c, d, done} !== 5'b0 || ready !== 1'b1) begin fails++; $display("FAIL rstmid_outs got=%b ready=%b exp=00000/1", {a, b, c, d, done}, ready); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_frame_cnt got=%0d exp=0", frame_cnt); end
    rst_n = 1'b1; start = 1'b0; tick();
    sample_window(6);
    tests++; if ((ah | bh | ch | dh) !== 64'd0) begin fails++; $display("FAIL rstmid_no_partial got a=%h b=%h c=%h d=%h exp=0", ah, bh, ch, dh); end
  endtask

  task automatic test_sweep_ignore();
    logic [63:0] h_a, h_b, h_c, h_d;
    logic [7:0]  f0;
    f0 = frame_cnt1;
    h_a = '0; h_b = '0; h_c = '0; h_d = '0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      h_a[i] = a1; h_b[i] = b1; h_c[i] = c1; h_d[i] = d1;
      start1 = (i == 1);            // pulse during WAIT_B must be dropped
      tick();
    end
    start1 = 1'b0;
    tests++; if (h_a[11:0] !== 12'h001) begin fails++; $display("FAIL sweep_a got=%h exp=001", h_a[11:0]); end
    tests++; if (h_b[11:0] !== 12'h008) begin fails++; $display("FAIL sweep_b got=%h exp=008", h_b[11:0]); end
    tests++; if (h_c[11:0] !== 12'h010) begin fails++; $display("FAIL sweep_c got=%h exp=010", h_c[11:0]); end
    tests++; if (h_d[11:0] !== 12'h100) begin fails++; $display("FAIL sweep_d got=%h exp=100", h_d[11:0]); end
    tests++; if (frame_cnt1 !== f0 + 8'd1) begin fails++; $display("FAIL sweep_frame_cnt got=%0d exp=%0d", frame_cnt1, f0 + 8'd1); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    start = 1'b1; tick();           // offset 1
    repeat (1530) tick();           // offset 1531: 255 frames complete
    tests++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255 got=%0d exp=255", frame_cnt); end
    repeat (5) tick();              // offset 1536: DRV_D of frame 256
    start = 1'b0; tick();
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_zero got=%0d exp=0", frame_cnt); end
    tests++; if (a !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL wrap_idle got a=%b ready=%b exp 0/1", a, ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_sweep_ignore();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
